// File: rtl/noc_port_arbiter.sv
// noc_port_arbiter: round-robin N:1 flit arbiter with a single output register stage
// and a saturating count of flits delivered downstream.
module noc_port_arbiter #(
    parameter int N = 5,
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   i_valid,
    input  logic [N*W-1:0] i_data,
    output logic [N-1:0]   o_ready,
    input  logic [N-1:0]   i_mask,
    output logic           o_valid,
    output logic [W-1:0]   o_data,
    input  logic           i_ready,
    output logic [N-1:0]   o_src,
    output logic [15:0]    o_flit_cnt
);
    localparam int PW = N > 1 ? $clog2(N) : 1;

    typedef enum logic {EMPTY, FULL} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d, win;
    logic [W-1:0]  data_q, data_d;
    logic [N-1:0]  src_q, src_d, req;
    logic [15:0]   cnt_q, cnt_d;
    logic          found, free, grant, down;
    int            idx;

    always_comb begin
        req = i_valid & i_mask;
        free = state_q == EMPTY || i_ready;
        down = state_q == FULL && i_ready;
        win = '0;
        found = 1'b0;
        idx = 0;
        // search starts one past the last winner and wraps
        for (int i = 1; i <= N; i++) begin
            idx = (int'(ptr_q) + i) % N;
            if (!found && req[idx]) begin
                found = 1'b1;
                win = PW'(idx);
            end
        end
        o_ready = (free && found && !rst) ? N'(1) << win : '0;
        grant = |o_ready;
        state_d = state_q;
        ptr_d = ptr_q;
        data_d = data_q;
        src_d = src_q;
        cnt_d = (down && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
        if (grant) begin
            state_d = FULL;
            ptr_d = win;
            data_d = i_data[int'(win)*W +: W];
            src_d = o_ready;
        end else if (down) begin
            state_d = EMPTY;
            src_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            ptr_q <= PW'(N - 1);
            data_q <= '0;
            src_q <= '0;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            data_q <= data_d;
            src_q <= src_d;
            cnt_q <= cnt_d;
        end
    end

    assign o_valid = state_q == FULL;
    assign o_data = data_q;
    assign o_src = src_q;
    assign o_flit_cnt = cnt_q;
endmodule

// File: tb/tb_noc_port_arbiter.sv
// tb_noc_port_arbiter: directed scenarios plus randomized traffic, all checked
// cycle by cycle against a behavioural round-robin model.
module tb_noc_port_arbiter;
    localparam int N = 5;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   i_valid, i_mask, o_ready, o_src;
    logic [N*W-1:0] i_data;
    logic           o_valid, i_ready;
    logic [W-1:0]   o_data;
    logic [15:0]    o_flit_cnt;

    noc_port_arbiter #(.N(N), .W(W)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data), .o_ready(o_ready),
        .i_mask(i_mask), .o_valid(o_valid), .o_data(o_data), .i_ready(i_ready),
        .o_src(o_src), .o_flit_cnt(o_flit_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model state
    int         m_ptr = N - 1;
    bit         m_full = 0;
    logic [W-1:0] m_data = '0;
    int         m_src = 0;
    int         m_cnt = 0;
    int         m_win = -1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick();
        if (rst || (m_full && !i_ready)) return -1;
        for (int i = 1; i <= N; i++) begin
            int k = (m_ptr + i) % N;
            if (i_valid[k] && i_mask[k]) return k;
        end
        return -1;
    endfunction

    // inputs are already driven; compare, clock once, advance the model
    task automatic step();
        logic [N-1:0] exp_rdy;
        bit deliver;
        #1;
        m_win = pick();
        exp_rdy = (m_win < 0) ? '0 : N'(1) << m_win;
        check("ready", 32'(o_ready), 32'(exp_rdy));
        check("valid", 32'(o_valid), 32'(m_full));
        if (m_full) check("data", 32'(o_data), 32'(m_data));
        check("src", 32'(o_src), m_full ? 32'(1) << m_src : 32'd0);
        check("cnt", 32'(o_flit_cnt), 32'(m_cnt));
        @(posedge clk);
        if (rst) begin
            m_full = 0; m_ptr = N - 1; m_cnt = 0;
        end else begin
            deliver = m_full && i_ready;
            if (deliver && m_cnt < 65535) m_cnt++;
            if (m_win >= 0) begin
                m_full = 1; m_data = i_data[m_win*W +: W]; m_src = m_win; m_ptr = m_win;
            end else if (deliver) m_full = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1; i_valid = '0; step(); rst = 0;
    endtask

    initial begin
        rst = 1; i_valid = '0; i_mask = '1; i_data = '0; i_ready = 1;
        @(posedge clk); #1;
        i_valid = '1;
        step();
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_cnt", 32'(o_flit_cnt), 32'd0);
        rst = 0;
        // single requester
        i_valid = 5'b00001; i_data = '0; i_data[7:0] = 8'hA5; i_mask = '1; i_ready = 1;
        #1 check("single_rdy", 32'(o_ready), 32'b00001);
        step();
        i_valid = '0;
        check("single_data", 32'(o_data), 32'hA5);
        check("single_src", 32'(o_src), 32'b00001);
        step();
        // round robin from reset
        do_reset();
        i_valid = '1;
        for (int k = 0; k < N; k++) i_data[k*W +: W] = 8'h10 + 8'(k);
        for (int s = 0; s < 6; s++) begin
            step();
            check("rr_src", 32'(o_src), 32'(1) << (s % N));
        end
        check("rr_cnt5", 32'(o_flit_cnt), 32'd5);
        // backpressure
        do_reset();
        i_valid = 5'b00001; i_data[7:0] = 8'h3C;
        step();
        i_ready = 0; i_valid = 5'b00100; i_data[23:16] = 8'h5A;
        for (int s = 0; s < 4; s++) begin
            #1 check("bp_rdy", 32'(o_ready), 32'd0);
            step();
            check("bp_data", 32'(o_data), 32'h3C);
        end
        i_ready = 1;
        step();
        i_valid = '0;
        check("bp_data2", 32'(o_data), 32'h5A);
        check("bp_src2", 32'(o_src), 32'b00100);
        step();
        // masking
        do_reset();
        i_valid = 5'b10010; i_mask = 5'b01111;
        for (int s = 0; s < 4; s++) begin
            step();
            check("mask_src", 32'(o_src), 32'b00010);
        end
        i_mask = '1;
        step();
        check("unmask_src", 32'(o_src), 32'b10000);
        // reset while full and stalled
        do_reset();
        i_valid = 5'b01000; i_data[31:24] = 8'h77;
        step();
        i_ready = 0; i_valid = '0;
        step();
        check("hold77", 32'(o_data), 32'h77);
        do_reset();
        check("mid_rst_valid", 32'(o_valid), 32'd0);
        check("mid_rst_cnt", 32'(o_flit_cnt), 32'd0);
        i_ready = 1; i_valid = '1;
        step();
        check("mid_rst_first", 32'(o_src), 32'b00001);
        // randomized traffic with requesters that hold flits until accepted
        do_reset();
        i_valid = '0;
        for (int s = 0; s < 3000; s++) begin
            for (int k = 0; k < N; k++)
                if (!i_valid[k] && $urandom_range(0, 2) == 0) begin
                    i_valid[k] = 1; i_data[k*W +: W] = 8'($urandom);
                end
            if ($urandom_range(0, 15) == 0) i_mask = 5'($urandom);
            i_ready = $urandom_range(0, 3) != 0;
            rst = $urandom_range(0, 199) == 0;
            step();
            if (m_win >= 0) i_valid[m_win] = 0;
            rst = 0;
        end
        // counter saturation
        do_reset();
        i_valid = '1; i_mask = '1; i_ready = 1;
        for (int s = 0; s < 65542; s++) step();
        check("sat_cnt", 32'(o_flit_cnt), 32'hFFFF);
        step();
        check("sat_hold", 32'(o_flit_cnt), 32'hFFFF);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
